way_replacement_unit: RTL and testbench

- Per-set victim selection for the N-way set-associative cache controller; sits directly downstream of the way-lookup/tag-compare stage.
- Tracks valid bits and true-LRU ages for every set. Hit lookups update recency.
- On a fill request, returns a one-hot way: the lowest-index invalid way if one exists, otherwise the LRU way. Reports whether the chosen way holds a valid line that must be evicted.

---
 rtl/way_replacement_unit_pkg.sv | 30 +++
 rtl/way_replacement_unit_if.sv | 38 +++
 rtl/way_replacement_unit_lru_age_update.sv | 41 ++++
 rtl/way_replacement_unit.sv | 178 +++++++++++++++++
 tb/tb_way_replacement_unit.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/way_replacement_unit_pkg.sv
// Shared types, constants and helpers for the way replacement unit.
package way_replacement_unit_pkg;

    // Ceiling log2 for width derivation; returns 0 for values <= 1.
    function automatic int unsigned wru_log2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    localparam int unsigned WRU_NUMBER_OF_WAYS = 4;
    localparam int unsigned WRU_NUMBER_OF_SETS = 64;
    localparam int unsigned WRU_INDEX_BITS     = wru_log2(WRU_NUMBER_OF_SETS);
    localparam int unsigned WRU_AGE_BITS       = wru_log2(WRU_NUMBER_OF_WAYS);

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_RESPOND = 2'd2
    } wru_state_e;

    // Per-set age vector for the default configuration: way w occupies bits [w*AGE_BITS +: AGE_BITS].
    typedef logic [WRU_NUMBER_OF_WAYS*WRU_AGE_BITS-1:0] wru_age_vec_t;

endpackage

// File: rtl/way_replacement_unit_if.sv
// Lookup/fill/invalidate signal bundle between the cache controller and the replacement unit.
interface way_replacement_unit_if
    import way_replacement_unit_pkg::*;
#(
    parameter int unsigned NUMBER_OF_WAYS = WRU_NUMBER_OF_WAYS,
    parameter int unsigned NUMBER_OF_SETS = WRU_NUMBER_OF_SETS
);
    localparam int unsigned INDEX_BITS = wru_log2(NUMBER_OF_SETS);

    logic                      access_valid;
    logic [INDEX_BITS-1:0]     access_index;
    logic [NUMBER_OF_WAYS-1:0] access_way;
    logic                      fill_req;
    logic [INDEX_BITS-1:0]     fill_index;
    logic                      fill_ready;
    logic                      fill_valid;
    logic [NUMBER_OF_WAYS-1:0] fill_way;
    logic                      fill_evict;
    logic                      inval_valid;
    logic [INDEX_BITS-1:0]     inval_index;
    logic [NUMBER_OF_WAYS-1:0] inval_way;
    logic                      init_done;

    modport master (
        output access_valid, access_index, access_way,
        output fill_req, fill_index,
        output inval_valid, inval_index, inval_way,
        input  fill_ready, fill_valid, fill_way, fill_evict, init_done
    );

    modport slave (
        input  access_valid, access_index, access_way,
        input  fill_req, fill_index,
        input  inval_valid, inval_index, inval_way,
        output fill_ready, fill_valid, fill_way, fill_evict, init_done
    );

endinterface

// File: rtl/way_replacement_unit_lru_age_update.sv
// Combinational true-LRU age update for one set: touch a way and report the current LRU way.
module way_replacement_unit_lru_age_update #(
    parameter int unsigned NUMBER_OF_WAYS = 4,
    parameter int unsigned AGE_BITS       = 2
) (
    input  logic [NUMBER_OF_WAYS*AGE_BITS-1:0] age_i,
    input  logic [NUMBER_OF_WAYS-1:0]          touch_way_i,
    output logic [NUMBER_OF_WAYS*AGE_BITS-1:0] age_o,
    output logic [NUMBER_OF_WAYS-1:0]          lru_way_o
);

    logic [AGE_BITS-1:0] touched_age;
    logic [AGE_BITS-1:0] cur_age;

    // Younger ways than the touched one age by one; the touched way becomes MRU.
    always_comb begin
        touched_age = '0;
        cur_age     = '0;
        age_o       = age_i;
        lru_way_o   = '0;
        for (int unsigned w = 0; w < NUMBER_OF_WAYS; w++) begin
            if (touch_way_i[w]) begin
                touched_age = touched_age | age_i[w*AGE_BITS +: AGE_BITS];
            end
        end
        for (int unsigned w = 0; w < NUMBER_OF_WAYS; w++) begin
            cur_age = age_i[w*AGE_BITS +: AGE_BITS];
            if (cur_age == AGE_BITS'(NUMBER_OF_WAYS - 1)) begin
                lru_way_o[w] = 1'b1;
            end
            if (|touch_way_i) begin
                if (touch_way_i[w]) begin
                    age_o[w*AGE_BITS +: AGE_BITS] = '0;
                end else if (cur_age < touched_age) begin
                    age_o[w*AGE_BITS +: AGE_BITS] = cur_age + AGE_BITS'(1);
                end
            end
        end
    end

endmodule

// File: rtl/way_replacement_unit.sv
// Per-set victim selection with valid tracking and true-LRU ages.
module way_replacement_unit
    import way_replacement_unit_pkg::*;
#(
    parameter int unsigned NUMBER_OF_WAYS = WRU_NUMBER_OF_WAYS,
    parameter int unsigned NUMBER_OF_SETS = WRU_NUMBER_OF_SETS
) (
    input  logic                  clock,
    input  logic                  reset,
    way_replacement_unit_if.slave bus
);

    localparam int unsigned INDEX_BITS = wru_log2(NUMBER_OF_SETS);
    localparam int unsigned AGE_BITS   = wru_log2(NUMBER_OF_WAYS);
    localparam int unsigned AGE_W      = NUMBER_OF_WAYS * AGE_BITS;

    wru_state_e                state_q, state_d;
    logic [INDEX_BITS-1:0]     clr_cnt_q, clr_cnt_d;
    logic [INDEX_BITS-1:0]     fill_idx_q, fill_idx_d;
    logic [NUMBER_OF_WAYS-1:0] fill_way_q, fill_way_d;
    logic                      fill_evict_q, fill_evict_d;
    logic                      fill_ready_q, fill_ready_d;
    logic                      fill_valid_q, fill_valid_d;
    logic                      init_done_q, init_done_d;

    logic [NUMBER_OF_WAYS-1:0] valid_q [NUMBER_OF_SETS];
    logic [AGE_W-1:0]          age_q   [NUMBER_OF_SETS];

    logic [AGE_W-1:0]          age_ident_c;
    logic [NUMBER_OF_WAYS-1:0] fill_row_c;
    logic [NUMBER_OF_WAYS-1:0] sel_way_c;
    logic                      sel_evict_c;
    logic                      acc_apply_c;
    logic [NUMBER_OF_WAYS-1:0] inval_row_c;
    logic [AGE_W-1:0]          fill_age_in_c;
    logic [NUMBER_OF_WAYS-1:0] fill_touch_c;
    logic [AGE_W-1:0]          fill_age_new_c;
    logic [NUMBER_OF_WAYS-1:0] fill_lru_c;
    logic [AGE_W-1:0]          acc_age_new_c;
    logic [NUMBER_OF_WAYS-1:0] acc_lru_unused;

    // Fill port shares one updater: victim lookup while idle, commit touch while responding.
    assign fill_age_in_c = (state_q == ST_RESPOND) ? age_q[fill_idx_q] : age_q[bus.fill_index];
    assign fill_touch_c  = (state_q == ST_RESPOND) ? fill_way_q : '0;

    way_replacement_unit_lru_age_update #(
        .NUMBER_OF_WAYS (NUMBER_OF_WAYS),
        .AGE_BITS       (AGE_BITS)
    ) u_fill_age (
        .age_i       (fill_age_in_c),
        .touch_way_i (fill_touch_c),
        .age_o       (fill_age_new_c),
        .lru_way_o   (fill_lru_c)
    );

    way_replacement_unit_lru_age_update #(
        .NUMBER_OF_WAYS (NUMBER_OF_WAYS),
        .AGE_BITS       (AGE_BITS)
    ) u_access_age (
        .age_i       (age_q[bus.access_index]),
        .touch_way_i (bus.access_way),
        .age_o       (acc_age_new_c),
        .lru_way_o   (acc_lru_unused)
    );

    // Reset-time age layout: way i starts with age i.
    always_comb begin
        age_ident_c = '0;
        for (int unsigned w = 0; w < NUMBER_OF_WAYS; w++) begin
            age_ident_c[w*AGE_BITS +: AGE_BITS] = AGE_BITS'(w);
        end
    end

    // Victim choice: lowest invalid way (isolated lowest zero bit), else the LRU way.
    always_comb begin
        fill_row_c  = valid_q[bus.fill_index];
        sel_way_c   = ~fill_row_c & (fill_row_c + NUMBER_OF_WAYS'(1));
        sel_evict_c = 1'b0;
        if (&fill_row_c) begin
            sel_way_c   = fill_lru_c;
            sel_evict_c = 1'b1;
        end
    end

    // Access is dropped when it collides with the set being committed; invalidate lands after commit.
    always_comb begin
        acc_apply_c = bus.access_valid && (|bus.access_way) &&
                      !((state_q == ST_RESPOND) && (bus.access_index == fill_idx_q));
        inval_row_c = valid_q[bus.inval_index];
        if ((state_q == ST_RESPOND) && (bus.inval_index == fill_idx_q)) begin
            inval_row_c = inval_row_c | fill_way_q;
        end
        inval_row_c = inval_row_c & ~bus.inval_way;
    end

    // Next-state and output logic.
    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        fill_idx_d   = fill_idx_q;
        fill_way_d   = fill_way_q;
        fill_evict_d = fill_evict_q;
        case (state_q)
            ST_INIT: begin
                clr_cnt_d = clr_cnt_q + INDEX_BITS'(1);
                if (clr_cnt_q == INDEX_BITS'(NUMBER_OF_SETS - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (bus.fill_req) begin
                    state_d      = ST_RESPOND;
                    fill_idx_d   = bus.fill_index;
                    fill_way_d   = sel_way_c;
                    fill_evict_d = sel_evict_c;
                end
            end
            ST_RESPOND: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
        fill_ready_d = (state_d == ST_IDLE);
        fill_valid_d = (state_d == ST_RESPOND);
        init_done_d  = (state_d != ST_INIT);
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_INIT;
            clr_cnt_q    <= '0;
            fill_idx_q   <= '0;
            fill_way_q   <= '0;
            fill_evict_q <= 1'b0;
            fill_ready_q <= 1'b0;
            fill_valid_q <= 1'b0;
            init_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            fill_idx_q   <= fill_idx_d;
            fill_way_q   <= fill_way_d;
            fill_evict_q <= fill_evict_d;
            fill_ready_q <= fill_ready_d;
            fill_valid_q <= fill_valid_d;
            init_done_q  <= init_done_d;
        end
    end

    // Valid/age storage: sweep-clear during INIT, otherwise access, commit and invalidate updates.
    always_ff @(posedge clock) begin
        if (state_q == ST_INIT) begin
            valid_q[clr_cnt_q] <= '0;
            age_q[clr_cnt_q]   <= age_ident_c;
        end else if (!reset) begin
            if (acc_apply_c) begin
                age_q[bus.access_index] <= acc_age_new_c;
            end
            if (state_q == ST_RESPOND) begin
                age_q[fill_idx_q]   <= fill_age_new_c;
                valid_q[fill_idx_q] <= valid_q[fill_idx_q] | fill_way_q;
            end
            if (bus.inval_valid) begin
                valid_q[bus.inval_index] <= inval_row_c;
            end
        end
    end

    assign bus.fill_ready = fill_ready_q;
    assign bus.fill_valid = fill_valid_q;
    assign bus.fill_way   = fill_way_q;
    assign bus.fill_evict = fill_evict_q;
    assign bus.init_done  = init_done_q;

endmodule

// File: tb/tb_way_replacement_unit.sv
// Bench for way_replacement_unit: directed scenarios plus random traffic against a recency-list model.
module tb_way_replacement_unit;

    localparam int unsigned NW = 4;
    localparam int unsigned NS = 64;

    logic clock;
    logic reset;

    way_replacement_unit_if #(.NUMBER_OF_WAYS(NW), .NUMBER_OF_SETS(NS)) bus ();

    way_replacement_unit #(.NUMBER_OF_WAYS(NW), .NUMBER_OF_SETS(NS)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    // Model: per-set valid bits and a recency list, most recently used first.
    bit mvalid [NS][NW];
    int morder [NS][NW];
    bit m_resp;
    int p_idx;
    int p_way;
    bit p_ev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_init();
        for (int s = 0; s < NS; s++) begin
            for (int w = 0; w < NW; w++) begin
                mvalid[s][w] = 1'b0;
                morder[s][w] = w;
            end
        end
        m_resp = 1'b0;
    endfunction

    function automatic void touch(input int s, input int w);
        int p = 0;
        for (int i = 0; i < NW; i++) if (morder[s][i] == w) p = i;
        for (int i = p; i > 0; i--) morder[s][i] = morder[s][i-1];
        morder[s][0] = w;
    endfunction

    function automatic void victim(input int s, output int w, output bit ev);
        w  = morder[s][NW-1];
        ev = 1'b1;
        for (int i = NW - 1; i >= 0; i--) begin
            if (!mvalid[s][i]) begin
                w  = i;
                ev = 1'b0;
            end
        end
    endfunction

    function automatic int way_of(input logic [NW-1:0] oh);
        int r = -1;
        for (int i = 0; i < NW; i++) if (oh[i]) r = i;
        return r;
    endfunction

    task automatic clear_inputs();
        bus.access_valid = 1'b0;
        bus.access_index = '0;
        bus.access_way   = '0;
        bus.fill_req     = 1'b0;
        bus.fill_index   = '0;
        bus.inval_valid  = 1'b0;
        bus.inval_index  = '0;
        bus.inval_way    = '0;
    endtask

    // One clock of operation: predict from the driven inputs, advance, compare outputs.
    task automatic step();
        int vw;
        bit ve;
        int aw;
        bit nr;
        if (bus.access_valid && !$onehot0(bus.access_way)) begin
            $display("FAIL stimulus: illegal multi-hot access_way %b", bus.access_way);
            $fatal(1);
        end
        aw = way_of(bus.access_way);
        check("fill_ready", 32'(bus.fill_ready), m_resp ? 32'd0 : 32'd1);
        nr = 1'b0;
        if (!m_resp) begin
            if (bus.fill_req) begin
                victim(int'(bus.fill_index), vw, ve);
                p_idx = int'(bus.fill_index);
                p_way = vw;
                p_ev  = ve;
                nr    = 1'b1;
            end
            if (bus.access_valid && aw >= 0) touch(int'(bus.access_index), aw);
        end else begin
            mvalid[p_idx][p_way] = 1'b1;
            touch(p_idx, p_way);
            if (bus.access_valid && aw >= 0 && int'(bus.access_index) != p_idx)
                touch(int'(bus.access_index), aw);
        end
        if (bus.inval_valid) begin
            for (int i = 0; i < NW; i++) if (bus.inval_way[i]) mvalid[int'(bus.inval_index)][i] = 1'b0;
        end
        @(posedge clock);
        #1;
        m_resp = nr;
        check("fill_valid", 32'(bus.fill_valid), 32'(nr));
        if (nr) begin
            check("fill_way", 32'(bus.fill_way), 32'd1 << p_way);
            check("fill_evict", 32'(bus.fill_evict), 32'(p_ev));
        end
    endtask

    task automatic fill_accept(input int idx, output logic [NW-1:0] w, output logic e);
        bus.fill_req   = 1'b1;
        bus.fill_index = 6'(idx);
        step();
        bus.fill_req = 1'b0;
        w = bus.fill_way;
        e = bus.fill_evict;
    endtask

    task automatic fill(input int idx, output logic [NW-1:0] w, output logic e);
        fill_accept(idx, w, e);
        step();
    endtask

    task automatic access(input int idx, input logic [NW-1:0] way);
        bus.access_valid = 1'b1;
        bus.access_index = 6'(idx);
        bus.access_way   = way;
        step();
        clear_inputs();
    endtask

    task automatic inval(input int idx, input logic [NW-1:0] way);
        bus.inval_valid = 1'b1;
        bus.inval_index = 6'(idx);
        bus.inval_way   = way;
        step();
        clear_inputs();
    endtask

    // Reset, check cleared outputs, then time the initialisation sweep.
    task automatic do_reset(input string tag);
        int  n;
        bit  bad;
        clear_inputs();
        reset = 1'b1;
        @(posedge clock);
        #1;
        check({tag, "_valid"}, 32'(bus.fill_valid), 32'd0);
        check({tag, "_ready"}, 32'(bus.fill_ready), 32'd0);
        check({tag, "_way"}, 32'(bus.fill_way), 32'd0);
        check({tag, "_init_done"}, 32'(bus.init_done), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        model_init();
        reset = 1'b0;
        n   = 0;
        bad = 1'b0;
        while (bus.init_done !== 1'b1 && n < 200) begin
            if (bus.fill_ready !== 1'b0 || bus.fill_valid !== 1'b0 ||
                bus.fill_way !== '0 || bus.fill_evict !== 1'b0) bad = 1'b1;
            @(posedge clock);
            #1;
            n++;
        end
        check({tag, "_init_cycles"}, 32'(n), 32'd64);
        check({tag, "_init_outputs"}, 32'(bad), 32'd0);
        check({tag, "_idle_ready"}, 32'(bus.fill_ready), 32'd1);
    endtask

    initial begin
        logic [NW-1:0] w;
        logic          e;
        int            r;

        reset = 1'b1;
        clear_inputs();
        model_init();
        do_reset("rst");

        // Cold fills of set 5, then first eviction.
        for (int k = 0; k < 4; k++) begin
            fill(5, w, e);
            check("cold_way", 32'(w), 32'd1 << k);
            check("cold_evict", 32'(e), 32'd0);
        end
        fill(5, w, e);
        check("evict_way", 32'(w), 32'b0001);
        check("evict_flag", 32'(e), 32'd1);

        // Hits reorder recency.
        repeat (4) fill(6, w, e);
        access(6, 4'b0001);
        access(6, 4'b0100);
        access(6, 4'b0010);
        fill(6, w, e);
        check("lru_after_hits", 32'(w), 32'b1000);
        check("lru_after_hits_evict", 32'(e), 32'd1);
        fill(6, w, e);
        check("lru_next", 32'(w), 32'b0001);

        // Invalidated way is refilled without eviction.
        repeat (4) fill(9, w, e);
        inval(9, 4'b0100);
        fill(9, w, e);
        check("inval_refill_way", 32'(w), 32'b0100);
        check("inval_refill_evict", 32'(e), 32'd0);

        // Access to the committing set is dropped.
        repeat (4) fill(12, w, e);
        fill_accept(12, w, e);
        bus.access_valid = 1'b1;
        bus.access_index = 6'd12;
        bus.access_way   = 4'b0010;
        step();
        clear_inputs();
        fill(12, w, e);
        check("same_set_drop_way", 32'(w), 32'b0010);

        // Access to another set during commit applies.
        repeat (4) fill(13, w, e);
        repeat (4) fill(14, w, e);
        fill_accept(13, w, e);
        bus.access_valid = 1'b1;
        bus.access_index = 6'd14;
        bus.access_way   = 4'b0001;
        step();
        clear_inputs();
        fill(14, w, e);
        check("other_set_access_way", 32'(w), 32'b0010);
        fill(13, w, e);
        check("other_set_fill_way", 32'(w), 32'b0010);

        // Invalidate of the committing way wins.
        fill_accept(20, w, e);
        bus.inval_valid = 1'b1;
        bus.inval_index = 6'd20;
        bus.inval_way   = w;
        step();
        clear_inputs();
        fill(20, w, e);
        check("commit_inval_way", 32'(w), 32'b0001);
        check("commit_inval_evict", 32'(e), 32'd0);

        // Random mixed traffic over a few sets.
        for (int c = 0; c < 600; c++) begin
            bus.fill_req     = 1'($urandom_range(0, 1));
            bus.fill_index   = 6'($urandom_range(0, 3));
            bus.access_valid = 1'($urandom_range(0, 1));
            bus.access_index = 6'($urandom_range(0, 3));
            r = int'($urandom_range(0, 4));
            bus.access_way   = (r == 4) ? 4'b0000 : 4'(1 << r);
            bus.inval_valid  = ($urandom_range(0, 3) == 0);
            bus.inval_index  = 6'($urandom_range(0, 3));
            r = int'($urandom_range(0, 3));
            bus.inval_way    = 4'(1 << r);
            step();
        end
        clear_inputs();
        if (m_resp) step();

        // Reset while a response is pending.
        fill_accept(5, w, e);
        do_reset("mid_rst");
        fill(5, w, e);
        check("post_reset_way", 32'(w), 32'b0001);
        check("post_reset_evict", 32'(e), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
